// File: rtl/servo_ramp_ctrl.sv
// Servo position sequencer for the PWM generator: maps 8-bit commands to pulse widths and
// moves the duty only at frame boundaries. Define SERVO_SLEW_EN to limit the change per frame to STEP.
module servo_ramp_ctrl #(
  parameter int unsigned PERIOD   = 500000,
  parameter int unsigned DUTY_MIN = 25000,
  parameter int unsigned DUTY_MAX = 50000,
  parameter int unsigned STEP     = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_pos,
  output logic        cmd_ready,
  input  logic        enable,
  output logic [31:0] duty_cycle,
  output logic [31:0] period,
  output logic        frame_tick,
  output logic        busy,
  output logic        at_target
);

  localparam logic [31:0] CENTER   = 32'(DUTY_MIN + (DUTY_MAX - DUTY_MIN) / 2);
  localparam logic [31:0] SPAN     = 32'(DUTY_MAX - DUTY_MIN);
  localparam logic [31:0] LAST_CNT = 32'(PERIOD - 1);

  if (STEP == 0 || DUTY_MIN >= DUTY_MAX || DUTY_MAX > PERIOD) begin : g_bad_params
    $error("servo_ramp_ctrl: inconsistent STEP/DUTY_MIN/DUTY_MAX/PERIOD");
  end

  typedef enum logic [1:0] {IDLE, CALC, RAMP} state_t;

  state_t      state, state_nxt;
  logic [31:0] frame_cnt, cnt_nxt;
  logic [7:0]  pos_q;
  logic [31:0] target, duty_cur, duty_next, stepped, mapped;
  logic [39:0] prod;
  logic        xfer;

  assign cmd_ready = (state != CALC);
  assign busy      = (state != IDLE);
  assign at_target = (state == IDLE);
  assign period    = PERIOD;
  assign xfer      = cmd_valid && cmd_ready;

  assign cnt_nxt = (frame_cnt == LAST_CNT) ? 32'd0 : frame_cnt + 32'd1;

  // Position 255 is pinned to DUTY_MAX; the shift alone would land just short of it.
  always_comb begin
    prod   = 40'(pos_q) * 40'(SPAN);
    mapped = (pos_q == 8'hFF) ? DUTY_MAX : DUTY_MIN + prod[39:8];
  end

`ifdef SERVO_SLEW_EN
  logic        up;
  logic [31:0] diff;

  always_comb begin
    up   = (target > duty_cur);
    diff = up ? target - duty_cur : duty_cur - target;
    if (diff <= STEP) stepped = target;
    else              stepped = up ? duty_cur + STEP : duty_cur - STEP;
  end
`else
  assign stepped = target;
`endif

  assign duty_next = (state == RAMP && frame_tick) ? stepped : duty_cur;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (xfer) state_nxt = CALC;
      CALC: state_nxt = (mapped == duty_cur) ? IDLE : RAMP;
      RAMP: begin
        if (xfer)                                state_nxt = CALC;
        else if (frame_tick && stepped == target) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every process samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_cnt  <= 32'd0;
      frame_tick <= 1'b0;
      duty_cycle <= 32'd0;
      duty_cur   <= CENTER;
      target     <= CENTER;
      pos_q      <= 8'd0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= cnt_nxt;
      frame_tick <= (cnt_nxt == LAST_CNT);
      duty_cur   <= duty_next;
      if (frame_tick)    duty_cycle <= enable ? duty_next : 32'd0;
      if (xfer)          pos_q      <= cmd_pos;
      if (state == CALC) target     <= mapped;
    end
  end

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with PERIOD=100, DUTY_MIN=20, DUTY_MAX=40, STEP=4;
// expected duty per frame comes from a small reference model through a scoreboard queue.
module tb_servo_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_pos;
  logic        cmd_ready;
  logic        enable;
  logic [31:0] duty_cycle;
  logic [31:0] period;
  logic        frame_tick;
  logic        busy;
  logic        at_target;

  servo_ramp_ctrl #(
    .PERIOD(100), .DUTY_MIN(20), .DUTY_MAX(40), .STEP(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_pos(cmd_pos),
    .cmd_ready(cmd_ready), .enable(enable), .duty_cycle(duty_cycle),
    .period(period), .frame_tick(frame_tick), .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_q[$];
  int unsigned m_cur, m_tgt;
  bit          m_en;
  int          n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned map_pos(input logic [7:0] p);
    if (p == 8'd255) return 40;
    return 20 + (int'(p) * 20) / 256;
  endfunction

  function automatic int unsigned model_step(input int unsigned cur, input int unsigned tgt);
`ifdef SERVO_SLEW_EN
    if (tgt > cur) return (tgt - cur <= 4) ? tgt : cur + 4;
    return (cur - tgt <= 4) ? tgt : cur - 4;
`else
    return tgt;
`endif
  endfunction

  // Waits (bounded) for frame_tick sampled on a falling edge; reports edges waited.
  task automatic wait_tick(input string tag, output int cycles);
    bit seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        seen   = 1'b1;
        cycles = i + 1;
        break;
      end
    end
    check({tag, "_tick_seen"}, {31'b0, seen}, 32'd1);
  endtask

  task automatic frame_step(input string tag, output int cycles);
    wait_tick(tag, cycles);
    if (m_cur != m_tgt) m_cur = model_step(m_cur, m_tgt);
    exp_q.push_back(m_en ? m_cur : 0);
    @(negedge clk);
    check({tag, "_duty"}, duty_cycle, exp_q.pop_front());
    check({tag, "_tick_low"}, {31'b0, frame_tick}, 32'd0);
    check({tag, "_at_target"}, {31'b0, at_target}, {31'b0, m_cur == m_tgt});
  endtask

  task automatic ramp_all(input string tag);
    int c;
    for (int k = 0; k < 20 && m_cur != m_tgt; k++) frame_step(tag, c);
  endtask

  // Holds cmd_valid through the CALC cycle to show a single acceptance.
  task automatic send_cmd(input string tag, input logic [7:0] p);
    cmd_pos   = p;
    cmd_valid = 1'b1;
    check({tag, "_ready_pre"}, {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    check({tag, "_ready_calc"}, {31'b0, cmd_ready}, 32'd0);
    check({tag, "_busy_calc"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    m_tgt = map_pos(p);
    check({tag, "_ready_post"}, {31'b0, cmd_ready}, 32'd1);
    check({tag, "_busy_post"}, {31'b0, busy}, {31'b0, m_tgt != m_cur});
    @(negedge clk);
    check({tag, "_single_accept"}, {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_pos = 8'd0;
    m_cur = 30; m_tgt = 30; m_en = 1'b1;

    #1;
    check("rst_duty", duty_cycle, 32'd0);
    check("rst_tick", {31'b0, frame_tick}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_at_target", {31'b0, at_target}, 32'd1);
    check("rst_period", period, 32'd100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    frame_step("first_frame", n);
    check("first_tick_cycle", n, 32'd99);
    frame_step("second_frame", n);
    check("tick_spacing", n, 32'd99);
    check("period_const", period, 32'd100);

    send_cmd("pos0", 8'd0);
    ramp_all("ramp_to_20");

    send_cmd("pos255_a", 8'd255);
    frame_step("up_a1", n);
    frame_step("up_a2", n);
    send_cmd("retarget0", 8'd0);
    ramp_all("retarget_down");

    send_cmd("pos255_b", 8'd255);
    ramp_all("ramp_to_40");
    send_cmd("pos128", 8'd128);
    ramp_all("ramp_to_30");
    send_cmd("pos128_again", 8'd128);
    check("noop_at_target", {31'b0, at_target}, 32'd1);
    frame_step("hold_30", n);

    send_cmd("en_pos0", 8'd0);
    frame_step("en_step1", n);
    enable = 1'b0; m_en = 1'b0;
    frame_step("dis_step2", n);
    frame_step("dis_step3", n);
    enable = 1'b1; m_en = 1'b1;
    frame_step("reen", n);

    send_cmd("rst_pos255", 8'd255);
    frame_step("pre_reset", n);
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_duty", duty_cycle, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_at_target", {31'b0, at_target}, 32'd1);
    check("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("mid_rst_tick", {31'b0, frame_tick}, 32'd0);
    check("mid_rst_period", period, 32'd100);
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = 30; m_tgt = 30; m_en = 1'b1;
    frame_step("after_reset", n);
    check("after_reset_tick_cycle", n, 32'd99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
